// File: rtl/inst_fetch_if.sv
// ============================================================================
// Module   : inst_fetch_if
// Brief    : Instruction-memory and decode handshake bundle for inst_fetch.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Inst;
    logic [31:0] PC;
    logic        inst_valid;
    logic        inst_ready;
    logic        br_taken;
    logic [31:0] Imm;
    logic        misalign;
    logic [31:0] fetch_cnt;

    modport master (
        output imem_req, imem_addr, Inst, PC, inst_valid, misalign, fetch_cnt,
        input  imem_rvalid, imem_rdata, inst_ready, br_taken, Imm
    );

    modport slave (
        input  imem_req, imem_addr, Inst, PC, inst_valid, misalign, fetch_cnt,
        output imem_rvalid, imem_rdata, inst_ready, br_taken, Imm
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Brief    : RV32I fetch stage: PC register, imem req/rvalid handshake,
//            instruction hold for decode and next-PC / misalign trap logic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire logic      clk,
    input  wire logic      rst,
    inst_fetch_if.master   bus
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic        r_misalign;
    logic [31:0] r_cnt;

    logic        w_capture;
    logic        w_accept;
    logic [31:0] w_next_pc;
    logic        w_aligned;

    // Branch operands only matter on the accept cycle; the adder runs freely.
    assign w_next_pc = r_pc_out + (bus.br_taken ? bus.Imm : c_PC_STEP);
    assign w_aligned = (w_next_pc[1:0] == 2'b00);
    assign w_capture = (r_state == S_FETCH) && bus.imem_rvalid;
    assign w_accept  = (r_state == S_HOLD) && bus.inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: if (bus.imem_rvalid) w_state_nxt = S_HOLD;
            S_HOLD:  if (bus.inst_ready)  w_state_nxt = w_aligned ? S_FETCH : S_TRAP;
            S_TRAP:  w_state_nxt = S_TRAP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= PC_RESET;
            r_inst     <= NOP_INST;
            r_pc_out   <= PC_RESET;
            r_misalign <= 1'b0;
            r_cnt      <= 32'd0;
        end else begin
            if (w_capture) begin
                r_inst   <= bus.imem_rdata;
                r_pc_out <= r_pc;
            end
            if (w_accept) begin
                r_cnt <= r_cnt + 32'd1;
                // On a misaligned target the PC stays at the accepted address.
                if (w_aligned) begin
                    r_pc   <= w_next_pc;
                    r_inst <= NOP_INST;
                end else begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

    assign bus.imem_req   = (r_state == S_FETCH);
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = (r_state == S_HOLD);
    assign bus.Inst       = r_inst;
    assign bus.PC         = r_pc_out;
    assign bus.misalign   = r_misalign;
    assign bus.fetch_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Directed self-checking bench for inst_fetch (two PC_RESET values).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inst_fetch_if b0 ();
    inst_fetch_if b1 ();

    inst_fetch #(.PC_RESET(32'h0000_0000), .NOP_INST(32'h0000_0013)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.master)
    );

    inst_fetch #(.PC_RESET(32'hFFFF_FFFC), .NOP_INST(32'h0000_0013)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (b0.imem_req !== 1'b0 || b0.inst_valid !== 1'b0 || b0.Inst !== c_NOP ||
            b0.PC !== 32'h0 || b0.misalign !== 1'b0 || b0.fetch_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b Inst=%h PC=%h mis=%b cnt=%0d want 0 0 00000013 00000000 0 0",
                     b0.imem_req, b0.inst_valid, b0.Inst, b0.PC, b0.misalign, b0.fetch_cnt);
        end
        checks++;
        if (b1.PC !== 32'hFFFF_FFFC || b1.imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL reset_pc1: PC=%h addr=%h want fffffffc", b1.PC, b1.imem_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        b0.inst_ready = 1'b1;
        b0.br_taken   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b0.imem_req !== 1'b1 || b0.imem_addr !== 32'(4 * i) || b0.inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL zw_fetch%0d: req=%b addr=%h valid=%b want 1 %h 0",
                         i, b0.imem_req, b0.imem_addr, b0.inst_valid, 32'(4 * i));
            end
            b0.imem_rvalid = 1'b1;
            b0.imem_rdata  = 32'h0000_1000 + 32'(i);
            step();
            b0.imem_rvalid = 1'b0;
            checks++;
            if (b0.inst_valid !== 1'b1 || b0.imem_req !== 1'b0 ||
                b0.Inst !== 32'h0000_1000 + 32'(i) || b0.PC !== 32'(4 * i)) begin
                errors++;
                $display("FAIL zw_hold%0d: valid=%b req=%b Inst=%h PC=%h want 1 0 %h %h",
                         i, b0.inst_valid, b0.imem_req, b0.Inst, b0.PC,
                         32'h0000_1000 + 32'(i), 32'(4 * i));
            end
        end
        step();
        b0.inst_ready = 1'b0;
        checks++;
        if (b0.fetch_cnt !== 32'd3 || b0.imem_addr !== 32'hC || b0.Inst !== c_NOP) begin
            errors++;
            $display("FAIL zw_count: cnt=%0d addr=%h Inst=%h want 3 0000000c 00000013",
                     b0.fetch_cnt, b0.imem_addr, b0.Inst);
        end
    endtask

    task automatic test_wait_states();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (b0.imem_req !== 1'b1 || b0.imem_addr !== 32'h0 ||
                b0.inst_valid !== 1'b0 || b0.Inst !== c_NOP) begin
                errors++;
                $display("FAIL wait_cycle%0d: req=%b addr=%h valid=%b Inst=%h want 1 0 0 00000013",
                         k, b0.imem_req, b0.imem_addr, b0.inst_valid, b0.Inst);
            end
            b0.imem_rvalid = (k == 3);
            b0.imem_rdata  = (k == 3) ? 32'hAAAA_0001 : 32'hDEAD_0000 + 32'(k);
            step();
        end
        b0.imem_rvalid = 1'b1;
        b0.imem_rdata  = 32'hBAD0_BAD0;
        checks++;
        if (b0.inst_valid !== 1'b1 || b0.Inst !== 32'hAAAA_0001 || b0.PC !== 32'h0) begin
            errors++;
            $display("FAIL wait_capture: valid=%b Inst=%h PC=%h want 1 aaaa0001 0",
                     b0.inst_valid, b0.Inst, b0.PC);
        end
        step();
        b0.imem_rvalid = 1'b0;
        checks++;
        if (b0.Inst !== 32'hAAAA_0001 || b0.inst_valid !== 1'b1 || b0.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_rvalid_ignored: Inst=%h valid=%b req=%b want aaaa0001 1 0",
                     b0.Inst, b0.inst_valid, b0.imem_req);
        end
    endtask

    task automatic test_stall_branch();
        b0.inst_ready = 1'b1;
        b0.br_taken   = 1'b1;
        b0.Imm        = 32'h0000_0100;
        step();
        b0.inst_ready = 1'b0;
        checks++;
        if (b0.imem_addr !== 32'h100 || b0.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL branch_fwd: addr=%h req=%b want 00000100 1", b0.imem_addr, b0.imem_req);
        end
        b0.imem_rvalid = 1'b1;
        b0.imem_rdata  = 32'h1234_5678;
        step();
        b0.imem_rvalid = 1'b0;
        b0.Imm         = 32'h0000_0006;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (b0.inst_valid !== 1'b1 || b0.Inst !== 32'h1234_5678 ||
                b0.PC !== 32'h100 || b0.misalign !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d: valid=%b Inst=%h PC=%h mis=%b want 1 12345678 00000100 0",
                         k, b0.inst_valid, b0.Inst, b0.PC, b0.misalign);
            end
            step();
        end
        b0.inst_ready = 1'b1;
        b0.Imm        = 32'hFFFF_FFF0;
        step();
        b0.inst_ready = 1'b0;
        b0.br_taken   = 1'b0;
        checks++;
        if (b0.imem_addr !== 32'h0F0 || b0.imem_req !== 1'b1 || b0.misalign !== 1'b0) begin
            errors++;
            $display("FAIL branch_back: addr=%h req=%b mis=%b want 000000f0 1 0",
                     b0.imem_addr, b0.imem_req, b0.misalign);
        end
    endtask

    task automatic test_misalign();
        b0.imem_rvalid = 1'b1;
        b0.imem_rdata  = 32'h0000_0063;
        step();
        b0.imem_rvalid = 1'b0;
        b0.inst_ready  = 1'b1;
        b0.br_taken    = 1'b1;
        b0.Imm         = 32'h0000_0010;
        step();
        b0.inst_ready  = 1'b0;
        b0.imem_rvalid = 1'b1;
        step();
        b0.imem_rvalid = 1'b0;
        checks++;
        if (b0.PC !== 32'h100 || b0.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL mis_setup: PC=%h valid=%b want 00000100 1", b0.PC, b0.inst_valid);
        end
        b0.inst_ready = 1'b1;
        b0.Imm        = 32'h0000_0006;
        step();
        b0.inst_ready = 1'b0;
        b0.br_taken   = 1'b0;
        checks++;
        if (b0.misalign !== 1'b1 || b0.inst_valid !== 1'b0 || b0.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL mis_trap: mis=%b valid=%b req=%b want 1 0 0",
                     b0.misalign, b0.inst_valid, b0.imem_req);
        end
        b0.imem_rvalid = 1'b1;
        b0.inst_ready  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (b0.imem_req !== 1'b0 || b0.misalign !== 1'b1 ||
                b0.inst_valid !== 1'b0 || b0.imem_addr !== 32'h100) begin
                errors++;
                $display("FAIL trap_hold%0d: req=%b mis=%b valid=%b addr=%h want 0 1 0 00000100",
                         k, b0.imem_req, b0.misalign, b0.inst_valid, b0.imem_addr);
            end
        end
        b0.imem_rvalid = 1'b0;
        b0.inst_ready  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (b0.misalign !== 1'b0 || b0.fetch_cnt !== 32'd0 || b0.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL trap_reset: mis=%b cnt=%0d req=%b want 0 0 0",
                     b0.misalign, b0.fetch_cnt, b0.imem_req);
        end
        step();
        checks++;
        if (b0.imem_req !== 1'b1 || b0.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL trap_refetch: req=%b addr=%h want 1 0", b0.imem_req, b0.imem_addr);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (b1.imem_req !== 1'b1 || b1.imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_fetch: req=%b addr=%h want 1 fffffffc", b1.imem_req, b1.imem_addr);
        end
        b1.imem_rvalid = 1'b1;
        b1.imem_rdata  = 32'h0000_0033;
        step();
        b1.imem_rvalid = 1'b0;
        b1.inst_ready  = 1'b1;
        step();
        b1.inst_ready  = 1'b0;
        checks++;
        if (b1.imem_addr !== 32'h0 || b1.misalign !== 1'b0 ||
            b1.imem_req !== 1'b1 || b1.fetch_cnt !== 32'd1) begin
            errors++;
            $display("FAIL wrap_next: addr=%h mis=%b req=%b cnt=%0d want 0 0 1 1",
                     b1.imem_addr, b1.misalign, b1.imem_req, b1.fetch_cnt);
        end
    endtask

    task automatic test_reset_mid_fetch();
        // b0 sits in FETCH at 0x0 after the previous reset
        b0.imem_rvalid = 1'b1;
        b0.imem_rdata  = 32'h0000_0093;
        step();
        b0.imem_rvalid = 1'b0;
        b0.inst_ready  = 1'b1;
        step();
        b0.inst_ready  = 1'b0;
        checks++;
        if (b0.fetch_cnt !== 32'd1 || b0.imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d addr=%h want 1 00000004", b0.fetch_cnt, b0.imem_addr);
        end
        step();
        rst            = 1'b1;
        b0.imem_rvalid = 1'b1;
        b0.imem_rdata  = 32'hFEED_FACE;
        step();
        rst            = 1'b0;
        b0.imem_rvalid = 1'b0;
        checks++;
        if (b0.imem_req !== 1'b0 || b0.inst_valid !== 1'b0 || b0.Inst !== c_NOP ||
            b0.fetch_cnt !== 32'd0 || b0.PC !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: req=%b valid=%b Inst=%h cnt=%0d PC=%h want 0 0 00000013 0 0",
                     b0.imem_req, b0.inst_valid, b0.Inst, b0.fetch_cnt, b0.PC);
        end
        step();
        checks++;
        if (b0.imem_req !== 1'b1 || b0.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_refetch: req=%b addr=%h want 1 0", b0.imem_req, b0.imem_addr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        b0.imem_rvalid = 1'b0; b0.imem_rdata = 32'h0; b0.inst_ready = 1'b0;
        b0.br_taken    = 1'b0; b0.Imm        = 32'h0;
        b1.imem_rvalid = 1'b0; b1.imem_rdata = 32'h0; b1.inst_ready = 1'b0;
        b1.br_taken    = 1'b0; b1.Imm        = 32'h0;
        step();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_branch();
        test_misalign();
        test_wrap();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
